// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM handshake and memory-controller state types
// Exports word_t, ramstate_t (FREE/BUSY/ACCESS/ERROR), mcstate_t (IDLE/DGRANT/IGRANT/DLOCK).
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, DGRANT = 2'd1, IGRANT = 2'd2, DLOCK = 2'd3} mcstate_t;
endpackage

// File: rtl/cache_mem_responder_timer.sv
// access_timer: saturating cycle counter with clear, enable and terminal-count flag
// Ports: CLK, nRST (async, active-low); clr_i zeroes the count, en_i advances it;
// tc_o is high while the count sits at MAX-1, i.e. during the MAX-th enabled cycle.
module access_timer #(
  parameter int MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(MAX + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o  = cnt_q == W'(MAX - 1);
  assign cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: arbitrates icache/dcache word requests onto one RAM port
// Ports: CLK, nRST (async, active-low); icache iREN/iaddr -> iwait/iload;
// dcache dREN/dWEN/daddr/dstore -> dwait/dload; RAM ramREN/ramWEN/ramaddr/ramstore
// driven only while granted, ramload/ramstate returned; mem_err sticky error flag.
module cache_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int    LOCK_MAX = 4,
  parameter int    TIMEOUT  = 64,
  parameter word_t ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
);
  mcstate_t state_q, state_d;
  logic mem_err_q;
  logic dreq, dg, ig, req, acc, done, fail, lock_tc, tmo_tc;
  word_t rdata;
  assign dreq  = dREN | dWEN;
  assign dg    = state_q == DGRANT;
  assign ig    = state_q == IGRANT;
  assign req   = dg ? dreq : ig & iREN;
  assign acc   = ramstate == ACCESS;
  // A withdrawn request never completes; timeout is treated exactly like ERROR.
  assign done  = req & (acc | ramstate == ERROR | tmo_tc);
  assign fail  = done & ~acc;
  assign rdata = acc ? ramload : ERR_WORD;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = dreq ? DGRANT : iREN ? IGRANT : IDLE;
      DGRANT:  state_d = (!dreq || fail) ? IDLE : acc ? (daddr[2] ? IDLE : DLOCK) : DGRANT;
      IGRANT:  state_d = (!iREN || done) ? IDLE : IGRANT;
      default: state_d = dreq ? DGRANT : lock_tc ? IDLE : DLOCK;
    endcase
  end
  // Timer restarts on every state change so each grant gets a fresh budget.
  access_timer #(.MAX(TIMEOUT)) u_tmo (
    .CLK(CLK), .nRST(nRST), .clr_i(state_d != state_q), .en_i(dg | ig), .tc_o(tmo_tc)
  );
  access_timer #(.MAX(LOCK_MAX)) u_lock (
    .CLK(CLK), .nRST(nRST), .clr_i(state_q != DLOCK), .en_i(state_q == DLOCK && !dreq), .tc_o(lock_tc)
  );
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) begin
      state_q   <= IDLE;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_err_q <= mem_err_q | fail;
    end
  // Simultaneous dREN/dWEN is illegal; the write wins.
  assign ramWEN   = dg & dWEN;
  assign ramREN   = dg ? dREN & ~dWEN : ig & iREN;
  assign ramaddr  = dg ? daddr : ig ? iaddr : '0;
  assign ramstore = dg ? dstore : '0;
  assign dwait    = ~(dg & done);
  assign iwait    = ~(ig & done);
  assign dload    = (dg & done) ? rdata : '0;
  assign iload    = (ig & done) ? rdata : '0;
  assign mem_err  = mem_err_q;
endmodule

// File: doc/cache_mem_responder.md
Name: cache_mem_responder

Overview:
- Memory-side responder for the icache/dcache request protocol: accepts word requests (iREN/iaddr; dREN/dWEN/daddr/dstore) and answers with iwait/iload and dwait/dload.
- Arbitrates the two caches onto a single RAM port (ramREN/ramWEN/ramaddr/ramstore, ramload, ramstate).
- Data side has priority, plus a block lock so a two-word dcache fill or writeback completes without an interleaved instruction fetch.
- Sits between the cache pair and the RAM model/controller in the memory subsystem.

Parameters:
LOCK_MAX, 4, idle cycles a dcache block lock is held after word 0 completes before release
TIMEOUT, 64, cycles a granted access may wait for ramstate==ACCESS before forced error completion
ERR_WORD, 32'hBAD1BAD1, load value returned on an errored/timed-out access

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  0 = icache access completes this cycle
iload  out  32  icache read data
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  0 = dcache access completes this cycle
dload  out  32  dcache read data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data
ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
mem_err  out  1  sticky: set on ERROR or timeout, cleared only by reset

Behaviour:
- Reset: state IDLE, lock counter 0, timer 0, mem_err=0; iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- States: IDLE, DGRANT, IGRANT, DLOCK. Grant is registered; RAM is driven only from DGRANT/IGRANT.
- IDLE: if (dREN|dWEN) go DGRANT; else if iREN go IGRANT; else stay. Simultaneous requests go to DGRANT. Minimum latency: request in cycle N, RAM driven from N+1.
- DGRANT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - If ramstate==ACCESS: dwait=0, dload=ramload. Next state is DLOCK if daddr[2]==0, else IDLE.
  - dREN and dWEN both high is illegal: ramWEN wins, ramREN is forced 0.
- IGRANT: ramREN=iREN, ramaddr=iaddr, ramWEN=0. If ramstate==ACCESS: iwait=0, iload=ramload; next state IDLE.
- DLOCK: RAM idle.
  - dcache request present: go to DGRANT next cycle.
  - Otherwise the lock counter increments; when it reaches LOCK_MAX, go to IDLE.
  - iREN is not served while in DLOCK. The counter clears on entry.
- ERROR: ramstate==ERROR in DGRANT/IGRANT completes the granted access: wait=0, load=ERR_WORD, mem_err<=1, next IDLE (no lock).
- Timeout: the timer counts the cycles spent in DGRANT/IGRANT without ACCESS and clears on every state change. At TIMEOUT it behaves like ERROR for that cycle.
- Request withdrawn while granted (requester's REN/WEN low): RAM strobes drop the same cycle, no completion, next IDLE.
- iwait/dwait are 1 in every cycle other than the completion cycle of that requester. The non-granted requester's load output is 0.
- Exactly one completion per RAM ACCESS cycle; never both iwait=0 and dwait=0 in the same cycle.
- nRST asserted mid-access: immediate return to reset values; an in-flight RAM access is abandoned.

Decomposition:
- cpu_types_pkg gains ramstate_t (FREE/BUSY/ACCESS/ERROR) and mcstate_t (IDLE/DGRANT/IGRANT/DLOCK); word_t comes from that package.
- ERR_WORD stays a module parameter.
- One sub-module: access_timer, a saturating counter with clear, enable and terminal-count flag. It is instantiated twice: lock counter (LOCK_MAX) and timeout (TIMEOUT).

Test Plan:
- Single iREN, iaddr=0x40; RAM gives ACCESS at 3rd granted cycle with ramload=0x1234 -> iwait=0 exactly one cycle with iload=0x1234, state returns IDLE, mem_err=0.
- iREN and dREN asserted same cycle, daddr=0x80 -> ramaddr=0x80 first; iaddr is served only after the dcache completion and after the lock releases (daddr[2]=0 => DLOCK).
- Dcache writeback pair: dWEN at 0x100 then 0x104, dstore=0xAAAA/0xBBBB, iREN held throughout -> both RAM writes occur back-to-back with no ramaddr=iaddr in between; then the icache is served.
- Word-0 dcache read with no follow-up, iREN high -> DLOCK held exactly LOCK_MAX=4 cycles, then IDLE, then IGRANT.
- ramstate=ERROR during DGRANT -> dwait=0, dload=0xBAD1BAD1, mem_err=1 and it stays 1 across later clean accesses until nRST.
- RAM stuck BUSY for 64 cycles on iREN -> at the 64th cycle iwait=0, iload=0xBAD1BAD1, mem_err=1; nRST pulsed mid-access -> all outputs return to reset values asynchronously.
